// File: rtl/dual_and_or_7458_pkg.sv
// Shared constants and helpers for the 7458-style dual AND-OR gate.
package dual_and_or_7458_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int SAT_W         = 32;

  // Increment v by one unless it already equals max; never wraps.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max);
    logic [SAT_W-1:0] r;
    r = (v == max) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dual_and_or_7458_and_or_section.sv
// One AND-OR section: y = (&a) | (&b) with N-input AND terms.
module and_or_section #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         y
);

  assign y = (&a) | (&b);

endmodule

// File: rtl/dual_and_or_7458.sv
// Dual AND-OR gate (3-3 and 2-2 sections) with an optional clocked rise monitor
// built only when DUAL_AND_OR_7458_MONITOR_EN is defined.
module dual_and_or_7458
  import dual_and_or_7458_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p1a,
  input  logic             p1b,
  input  logic             p1c,
  input  logic             p1d,
  input  logic             p1e,
  input  logic             p1f,
  input  logic             p2a,
  input  logic             p2b,
  input  logic             p2c,
  input  logic             p2d,
  output logic             p1y,
  output logic             p2y,
  output logic             p1y_q,
  output logic             p2y_q,
  output logic [CNT_W-1:0] p1_rise_cnt,
  output logic [CNT_W-1:0] p2_rise_cnt
);

  and_or_section #(.N(3)) u_sec1 (
    .a ({p1a, p1b, p1c}),
    .b ({p1d, p1e, p1f}),
    .y (p1y)
  );

  and_or_section #(.N(2)) u_sec2 (
    .a ({p2a, p2b}),
    .b ({p2c, p2d}),
    .y (p2y)
  );

`ifdef DUAL_AND_OR_7458_MONITOR_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A rise is seen when the live output is 1 while its registered copy is still 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1y_q       <= 1'b0;
      p2y_q       <= 1'b0;
      p1_rise_cnt <= '0;
      p2_rise_cnt <= '0;
    end else begin
      p1y_q <= p1y;
      p2y_q <= p2y;
      if (p1y && !p1y_q)
        p1_rise_cnt <= CNT_W'(sat_inc(SAT_W'(p1_rise_cnt), SAT_W'(CNT_MAX)));
      if (p2y && !p2y_q)
        p2_rise_cnt <= CNT_W'(sat_inc(SAT_W'(p2_rise_cnt), SAT_W'(CNT_MAX)));
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign p1y_q       = 1'b0;
  assign p2y_q       = 1'b0;
  assign p1_rise_cnt = '0;
  assign p2_rise_cnt = '0;
`endif

endmodule

// File: tb/tb_dual_and_or_7458.sv
// Self-checking bench for dual_and_or_7458 (works with or without the monitor build).
module tb_dual_and_or_7458;

`ifdef DUAL_AND_OR_7458_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             p1a, p1b, p1c, p1d, p1e, p1f;
  logic             p2a, p2b, p2c, p2d;
  logic             p1y, p2y, p1y_q, p2y_q;
  logic [CNT_W-1:0] p1_rise_cnt, p2_rise_cnt;

  int checks   = 0;
  int failures = 0;

  dual_and_or_7458 #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p1a         (p1a),
    .p1b         (p1b),
    .p1c         (p1c),
    .p1d         (p1d),
    .p1e         (p1e),
    .p1f         (p1f),
    .p2a         (p2a),
    .p2b         (p2b),
    .p2c         (p2c),
    .p2d         (p2d),
    .p1y         (p1y),
    .p2y         (p2y),
    .p1y_q       (p1y_q),
    .p2y_q       (p2y_q),
    .p1_rise_cnt (p1_rise_cnt),
    .p2_rise_cnt (p2_rise_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] in1;
    logic [3:0] in2;
    logic       y1;
    logic       y2;
  } vec_t;

  vec_t vecs[8];

  // Model
  function automatic logic model1(input logic [5:0] v);
    return (v[5] & v[4] & v[3]) | (v[2] & v[1] & v[0]);
  endfunction

  function automatic logic model2(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  // Driver tasks
  task automatic set_in(input logic [5:0] v1, input logic [3:0] v2);
    {p1a, p1b, p1c, p1d, p1e, p1f} = v1;
    {p2a, p2b, p2c, p2d}           = v2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_mon(input string tag, input logic q1, input logic q2,
                           input logic [CNT_W-1:0] c1, input logic [CNT_W-1:0] c2);
    check({tag, "_p1y_q"}, 32'(p1y_q), MON ? 32'(q1) : 32'd0);
    check({tag, "_p2y_q"}, 32'(p2y_q), MON ? 32'(q2) : 32'd0);
    check({tag, "_p1_cnt"}, 32'(p1_rise_cnt), MON ? 32'(c1) : 32'd0);
    check({tag, "_p2_cnt"}, 32'(p2_rise_cnt), MON ? 32'(c2) : 32'd0);
  endtask

  logic [5:0]       r1;
  logic [3:0]       r2;
  logic             m_q2;
  logic [CNT_W-1:0] m_c2;
  logic             cur2;

  initial begin
    vecs[0] = '{6'b111000, 4'b1100, 1'b1, 1'b1};
    vecs[1] = '{6'b110110, 4'b1010, 1'b0, 1'b0};
    vecs[2] = '{6'b000111, 4'b0011, 1'b1, 1'b1};
    vecs[3] = '{6'b000000, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{6'b111111, 4'b1111, 1'b1, 1'b1};
    vecs[5] = '{6'b011011, 4'b0101, 1'b0, 1'b0};
    vecs[6] = '{6'b101101, 4'b1001, 1'b0, 1'b0};
    vecs[7] = '{6'b110111, 4'b0111, 1'b1, 1'b1};

    rst_n = 1'b0;
    set_in(6'd0, 4'd0);
    #1;
    check_mon("reset", 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].in1, vecs[i].in2);
      #1;
      check($sformatf("vec%0d_p1y", i), 32'(p1y), 32'(vecs[i].y1));
      check($sformatf("vec%0d_p2y", i), 32'(p2y), 32'(vecs[i].y2));
    end

    for (int i = 0; i < 64; i++) begin
      set_in(6'(i), 4'd0);
      #1;
      check($sformatf("exh1_%0d", i), 32'(p1y), 32'(model1(6'(i))));
    end
    for (int i = 0; i < 16; i++) begin
      set_in(6'd0, 4'(i));
      #1;
      check($sformatf("exh2_%0d", i), 32'(p2y), 32'(model2(4'(i))));
    end

    // Random vectors changed on both clock edges, reset held low
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      r1 = 6'($urandom_range(0, 63));
      r2 = 4'($urandom_range(0, 15));
      set_in(r1, r2);
      #1;
      check("rnd_pos_p1y", 32'(p1y), 32'(model1(r1)));
      check("rnd_pos_p2y", 32'(p2y), 32'(model2(r2)));
      @(negedge clk);
      r1 = 6'($urandom_range(0, 63));
      r2 = 4'($urandom_range(0, 15));
      set_in(r1, r2);
      #1;
      check("rnd_neg_p1y", 32'(p1y), 32'(model1(r1)));
      check("rnd_neg_p2y", 32'(p2y), 32'(model2(r2)));
    end
    check_mon("rnd_end", 1'b0, 1'b0, '0, '0);

    // Reset release with p1y already high counts as one rise
    @(negedge clk);
    set_in(6'b111000, 4'b0000);
    #1;
    check("pre_rel_p1y", 32'(p1y), 32'd1);
    check_mon("pre_rel", 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_mon("post_rel", 1'b1, 1'b0, 8'd1, '0);

    // Toggle p2y for 300 rises; counter must stop at 255
    m_q2 = 1'b0;
    m_c2 = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      case (i % 4)
        0: set_in(6'b111000, 4'b1100);
        1: set_in(6'b111000, 4'b1010);
        2: set_in(6'b111000, 4'b0011);
        default: set_in(6'b111000, 4'b0110);
      endcase
      cur2 = (i % 2 == 0);
      @(posedge clk);
      if (cur2 && !m_q2 && m_c2 != 8'd255) m_c2 = m_c2 + 8'd1;
      m_q2 = cur2;
      #1;
      check("tog_p2y", 32'(p2y), 32'(cur2));
      check_mon("tog", 1'b1, m_q2, 8'd1, m_c2);
    end
    check("sat_p2_cnt", 32'(p2_rise_cnt), MON ? 32'd255 : 32'd0);

    // Asynchronous reset clears monitor state before the next clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_mon("async_rst", 1'b0, 1'b0, '0, '0);
    check("async_rst_p1y", 32'(p1y), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
